// File: rtl/hamming_top.sv
// hamming_top: two-stage Hamming(7,4) encoder, single-bit error injector and correcting decoder
module hamming_top (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] data_in,
    input  logic       parity_type,
    input  logic [3:1] err_pos,
    output logic [7:1] code_out,
    output logic [4:1] data_out,
    output logic       error_d,
    output logic [3:1] parity_out
);
    logic       par_q;
    logic [3:1] err_q;
    logic [7:1] enc, flip, rx, fixed;
    logic [3:1] syn;
    always_comb begin
        enc = {data_in[4], data_in[3], data_in[2],
               data_in[2] ^ data_in[3] ^ data_in[4] ^ parity_type,
               data_in[1],
               data_in[1] ^ data_in[3] ^ data_in[4] ^ parity_type,
               data_in[1] ^ data_in[2] ^ data_in[4] ^ parity_type};
    end
    // Channel model: the corruption only reaches the decoder, never code_out.
    always_comb begin
        flip = '0;
        for (int i = 1; i <= 7; i++) flip[i] = (err_q == 3'(i));
        rx = code_out ^ flip;
        syn[1] = rx[1] ^ rx[3] ^ rx[5] ^ rx[7] ^ par_q;
        syn[2] = rx[2] ^ rx[3] ^ rx[6] ^ rx[7] ^ par_q;
        syn[3] = rx[4] ^ rx[5] ^ rx[6] ^ rx[7] ^ par_q;
        fixed = '0;
        for (int i = 1; i <= 7; i++) fixed[i] = rx[i] ^ (syn == 3'(i));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_out   <= '0;
            par_q      <= 1'b0;
            err_q      <= '0;
            data_out   <= '0;
            parity_out <= '0;
            error_d    <= 1'b0;
        end else begin
            code_out   <= enc;
            par_q      <= parity_type;
            err_q      <= err_pos;
            data_out   <= {fixed[7], fixed[6], fixed[5], fixed[3]};
            parity_out <= syn;
            error_d    <= |syn;
        end
    end
endmodule

// File: tb/tb_hamming_top.sv
// tb_hamming_top: randomized and directed checks of hamming_top against a position-rule Hamming model
module tb_hamming_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:1] data_in = '0;
    logic       parity_type = 1'b0;
    logic [3:1] err_pos = '0;
    logic [7:1] code_out;
    logic [4:1] data_out;
    logic       error_d;
    logic [3:1] parity_out;
    int checks = 0;
    int failures = 0;
    logic [4:1] sd[512];
    logic       sp[512];
    logic [3:1] se[512];
    int sn;

    hamming_top dut (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_type(parity_type),
        .err_pos(err_pos), .code_out(code_out), .data_out(data_out),
        .error_d(error_d), .parity_out(parity_out)
    );

    always #5 clk = ~clk;

    // Data fills the non-power-of-two positions; each parity position p covers every index with bit p set.
    function automatic logic [7:1] model_code(input logic [4:1] d, input logic pt);
        logic [7:1] c;
        int dp[4] = '{3, 5, 6, 7};
        logic x;
        c = '0;
        for (int k = 0; k < 4; k++) c[dp[k]] = d[k+1];
        for (int p = 1; p <= 4; p = p * 2) begin
            x = pt;
            for (int j = 1; j <= 7; j++) if ((j & p) != 0 && j != p) x = x ^ c[j];
            c[p] = x;
        end
        return c;
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if ({code_out, data_out, error_d, parity_out} !== 15'd0) begin
            failures++;
            $display("FAIL %s: code=%b data=%b err=%b syn=%b, all must be 0", name, code_out, data_out, error_d, parity_out);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero("reset_hold");
        rst = 1'b0;
        data_in = 4'b0101; parity_type = 1'b0; err_pos = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (code_out !== 7'b0101101) begin
            failures++;
            $display("FAIL reset_first_code: got %b want 0101101", code_out);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1 check_zero("reset_async");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic directed(input logic [4:1] d, input logic pt, input logic [3:1] e,
                            input logic [7:1] exp_code, input string name);
        data_in = d; parity_type = pt; err_pos = e;
        @(posedge clk); #1;
        data_in = ~d; parity_type = ~pt; err_pos = 3'd0;
        checks++;
        if (code_out !== exp_code) begin
            failures++;
            $display("FAIL %s code: got %b want %b", name, code_out, exp_code);
        end
        @(posedge clk); #1;
        checks++;
        if (data_out !== d || parity_out !== e || error_d !== (e != 0)) begin
            failures++;
            $display("FAIL %s decode: data=%b syn=%b err=%b want data=%b syn=%b err=%b",
                     name, data_out, parity_out, error_d, d, e, e != 0);
        end
    endtask

    task automatic test_directed;
        directed(4'b0101, 1'b0, 3'd0, 7'b0101101, "even_0101");
        directed(4'b1101, 1'b0, 3'd0, 7'b1100110, "even_1101");
        directed(4'b0111, 1'b0, 3'd0, 7'b0110100, "even_0111");
        directed(4'b0000, 1'b0, 3'd0, 7'b0000000, "even_0000");
        directed(4'b0000, 1'b1, 3'd0, 7'b0001011, "odd_0000");
        directed(4'b0101, 1'b0, 3'd5, 7'b0101101, "err5_0101");
    endtask

    task automatic run_stream(input string name);
        for (int i = 0; i <= sn; i++) begin
            if (i < sn) begin
                data_in = sd[i]; parity_type = sp[i]; err_pos = se[i];
            end else begin
                data_in = '0; parity_type = 1'b0; err_pos = '0;
            end
            @(posedge clk); #1;
            if (i < sn) begin
                checks++;
                if (code_out !== model_code(sd[i], sp[i])) begin
                    failures++;
                    $display("FAIL %s code[%0d]: got %b want %b", name, i, code_out, model_code(sd[i], sp[i]));
                end
            end
            if (i >= 1) begin
                checks++;
                if (data_out !== sd[i-1] || parity_out !== se[i-1] || error_d !== (se[i-1] != 0)) begin
                    failures++;
                    $display("FAIL %s decode[%0d]: data=%b syn=%b err=%b want data=%b syn=%b err=%b",
                             name, i - 1, data_out, parity_out, error_d, sd[i-1], se[i-1], se[i-1] != 0);
                end
            end
        end
    endtask

    task automatic test_error_sweep;
        sn = 0;
        for (int d = 0; d < 16; d++)
            for (int p = 0; p < 2; p++)
                for (int e = 0; e < 8; e++) begin
                    sd[sn] = 4'(d); sp[sn] = 1'(p); se[sn] = 3'(e);
                    sn++;
                end
        run_stream("sweep");
    endtask

    task automatic test_back_to_back;
        sn = 300;
        for (int i = 0; i < sn; i++) begin
            sd[i] = 4'($urandom_range(0, 15));
            sp[i] = 1'(i % 2);
            se[i] = 3'($urandom_range(0, 7));
        end
        run_stream("b2b");
    endtask

    task automatic test_mid_reset;
        data_in = 4'b1011; parity_type = 1'b1; err_pos = 3'd6;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check_zero("midreset_async");
        data_in = '0; parity_type = 1'b0; err_pos = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (data_out !== 4'b0000 || error_d !== 1'b0 || parity_out !== 3'd0) begin
                failures++;
                $display("FAIL midreset_flush[%0d]: data=%b err=%b syn=%b want 0000/0/000", c, data_out, error_d, parity_out);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_error_sweep;
        test_back_to_back;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
